// File: rtl/serialarb.sv
// Multi-channel command arbiter: one command slot per channel, one grant per cycle onto a
// shared downstream port, response routed back to the last granted channel. Build option SERIALARB_PRIO_EN.
module serialarb #(
    parameter int NUM_CH = 2,
    parameter int SEQ_W  = 6,
    parameter int ADR_W  = 16,
    parameter int DAT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       ch_stb_i,
    input  logic [NUM_CH-1:0]       ch_we_i,
    input  logic [NUM_CH*SEQ_W-1:0] ch_seq_i,
    input  logic [NUM_CH*ADR_W-1:0] ch_adr_i,
    input  logic [NUM_CH*DAT_W-1:0] ch_dat_i,
    output logic [NUM_CH-1:0]       ch_tx_avail,
    output logic [DAT_W-1:0]        ch_tx_data,
    input  logic [NUM_CH-1:0]       ch_tx_pull,
    output logic [NUM_CH-1:0]       ch_ovf,
    input  logic                    ovf_clr,
    output logic                    stb_o,
    output logic                    we_o,
    output logic [SEQ_W-1:0]        seq_o,
    output logic [ADR_W-1:0]        adr_o,
    output logic [DAT_W-1:0]        dat_o,
    input  logic                    tx_avail,
    input  logic [DAT_W-1:0]        tx_data,
    output logic                    tx_pull
);

    localparam int IDX_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] full_q, full_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] elig, gnt, load;
    logic              slot_we_q  [NUM_CH];
    logic [SEQ_W-1:0]  slot_seq_q [NUM_CH];
    logic [ADR_W-1:0]  slot_adr_q [NUM_CH];
    logic [DAT_W-1:0]  slot_dat_q [NUM_CH];

    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;

    logic              stb_q, we_q;
    logic [SEQ_W-1:0]  seq_q;
    logic [ADR_W-1:0]  adr_q;
    logic [DAT_W-1:0]  dat_q;

    // While a response is in flight only the owner may be granted again.
    always_comb begin
        elig = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            elig[k] = full_q[k] && (!tx_avail || (owner_q == IDX_W'(k)));
        end
    end

`ifdef SERIALARB_PRIO_EN
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (elig[i]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
    end
`else
    localparam logic [IDX_W:0] NCH = (IDX_W+1)'(NUM_CH);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Circular search from the pointer; the sum is folded back explicitly so that
    // non-power-of-two channel counts never index past NUM_CH-1.
    always_comb begin
        logic [IDX_W:0] sum;
        sum     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (sum >= NCH) begin
                sum = sum - NCH;
            end
            if (!gnt_any && elig[sum[IDX_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        gnt = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
        load    = ch_stb_i & (~full_q | gnt);
        full_d  = (full_q & ~gnt) | load;
        ovf_d   = (ovf_clr ? '0 : ovf_q) | (ch_stb_i & full_q & ~gnt);
        owner_d = gnt_any ? gnt_idx : owner_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= '0;
            ovf_q   <= '0;
            owner_q <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                slot_we_q[k]  <= 1'b0;
                slot_seq_q[k] <= '0;
                slot_adr_q[k] <= '0;
                slot_dat_q[k] <= '0;
            end
        end else begin
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            owner_q <= owner_d;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (load[k]) begin
                    slot_we_q[k]  <= ch_we_i[k];
                    slot_seq_q[k] <= ch_seq_i[k*SEQ_W +: SEQ_W];
                    slot_adr_q[k] <= ch_adr_i[k*ADR_W +: ADR_W];
                    slot_dat_q[k] <= ch_dat_i[k*DAT_W +: DAT_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            seq_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
        end else begin
            stb_q <= gnt_any;
            if (gnt_any) begin
                we_q  <= slot_we_q[gnt_idx];
                seq_q <= slot_seq_q[gnt_idx];
                adr_q <= slot_adr_q[gnt_idx];
                dat_q <= slot_dat_q[gnt_idx];
            end
        end
    end

    always_comb begin
        ch_tx_avail          = '0;
        ch_tx_avail[owner_q] = tx_avail;
    end

    assign tx_pull    = ch_tx_pull[owner_q];
    assign ch_tx_data = tx_data;
    assign ch_ovf     = ovf_q;
    assign stb_o      = stb_q;
    assign we_o       = we_q;
    assign seq_o      = seq_q;
    assign adr_o      = adr_q;
    assign dat_o      = dat_q;

endmodule

// File: tb/tb_serialarb.sv
// Scoreboard bench for serialarb (NUM_CH=3): directed scenarios followed by random traffic,
// checked against a slot/queue level reference model.
module tb_serialarb;
    localparam int N  = 3;
    localparam int SW = 6;
    localparam int AW = 16;
    localparam int DW = 8;

    logic            clk, rst_n;
    logic [N-1:0]    ch_stb_i, ch_we_i, ch_tx_pull;
    logic [N*SW-1:0] ch_seq_i;
    logic [N*AW-1:0] ch_adr_i;
    logic [N*DW-1:0] ch_dat_i;
    logic [N-1:0]    ch_tx_avail, ch_ovf;
    logic [DW-1:0]   ch_tx_data, tx_data, dat_o;
    logic            ovf_clr, stb_o, we_o, tx_avail, tx_pull;
    logic [SW-1:0]   seq_o;
    logic [AW-1:0]   adr_o;

    serialarb #(.NUM_CH(N), .SEQ_W(SW), .ADR_W(AW), .DAT_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_stb_i(ch_stb_i), .ch_we_i(ch_we_i), .ch_seq_i(ch_seq_i),
        .ch_adr_i(ch_adr_i), .ch_dat_i(ch_dat_i),
        .ch_tx_avail(ch_tx_avail), .ch_tx_data(ch_tx_data), .ch_tx_pull(ch_tx_pull),
        .ch_ovf(ch_ovf), .ovf_clr(ovf_clr),
        .stb_o(stb_o), .we_o(we_o), .seq_o(seq_o), .adr_o(adr_o), .dat_o(dat_o),
        .tx_avail(tx_avail), .tx_data(tx_data), .tx_pull(tx_pull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic          we;
        logic [SW-1:0] seq;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        int            cyc;
    } cmd_t;

    cmd_t   exp_q[$];
    cmd_t   m_slot[N];
    bit     m_full[N];
    logic [N-1:0] m_ovf;
    int     m_owner, m_ptr, cyc;
    cmd_t   last;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_full[k] = 0;
        end
        m_ovf   = '0;
        m_owner = 0;
        m_ptr   = 0;
        exp_q.delete();
        last = '{we: 1'b0, seq: '0, adr: '0, dat: '0, cyc: 0};
    endtask

    task automatic model_step();
        int g;
        bit elig[N];
        cmd_t e;
        g = -1;
        for (int k = 0; k < N; k++) elig[k] = m_full[k] && (!tx_avail || k == m_owner);
`ifdef SERIALARB_PRIO_EN
        for (int k = 0; k < N; k++) if (elig[k]) g = k;
`else
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (g < 0 && elig[c]) g = c;
        end
`endif
        cyc++;
        if (g >= 0) begin
            e = m_slot[g];
            e.cyc = cyc;
            exp_q.push_back(e);
            m_owner = g;
            m_ptr = (g + 1) % N;
            m_full[g] = 0;
        end
        if (ovf_clr) m_ovf = '0;
        for (int k = 0; k < N; k++) begin
            if (ch_stb_i[k]) begin
                if (!m_full[k]) begin
                    m_full[k] = 1;
                    m_slot[k].we  = ch_we_i[k];
                    m_slot[k].seq = ch_seq_i[k*SW +: SW];
                    m_slot[k].adr = ch_adr_i[k*AW +: AW];
                    m_slot[k].dat = ch_dat_i[k*DW +: DW];
                end else begin
                    m_ovf[k] = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cmd_t e;
        logic [N-1:0] exp_av;
        if (stb_o) begin
            if (exp_q.size() == 0) begin
                chk("stb_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("stb_cycle", 64'(cyc), 64'(e.cyc));
                chk("cmd_fields", {we_o, seq_o, adr_o, dat_o}, {e.we, e.seq, e.adr, e.dat});
                last = e;
            end
        end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                chk("stb_missing", 0, 1);
                void'(exp_q.pop_front());
            end
            chk("hold_fields", {we_o, seq_o, adr_o, dat_o}, {last.we, last.seq, last.adr, last.dat});
        end
        exp_av = '0;
        exp_av[m_owner] = tx_avail;
        chk("ch_ovf", ch_ovf, m_ovf);
        chk("ch_tx_avail", ch_tx_avail, exp_av);
        chk("tx_pull", tx_pull, ch_tx_pull[m_owner]);
        chk("ch_tx_data", ch_tx_data, tx_data);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic set_cmd(input int k, input logic we, input logic [SW-1:0] s,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        ch_stb_i[k] = 1'b1;
        ch_we_i[k]  = we;
        ch_seq_i[k*SW +: SW] = s;
        ch_adr_i[k*AW +: AW] = a;
        ch_dat_i[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    logic [AW-1:0] adrs [N];
    int order [N];

    initial begin
        model_reset();
        cyc = 0;
        rst_n = 1'b0;
        ch_stb_i = '0; ch_we_i = '0; ch_seq_i = '0; ch_adr_i = '0; ch_dat_i = '0;
        ch_tx_pull = '0; ovf_clr = 1'b0; tx_avail = 1'b0; tx_data = 8'h5a;
        step();
        step();
        chk("reset_stb", stb_o, 0);
        chk("reset_adr", adr_o, 0);
        rst_n = 1'b1;
        step();

        // single command on channel 0: strobe in cycle 0, stb_o in cycle 2 only
        set_cmd(0, 1'b1, 6'h2a, 16'h1234, 8'hc3);
        step();
        ch_stb_i = '0;
        chk("lat_c1_stb", stb_o, 0);
        step();
        chk("lat_c2_stb", stb_o, 1);
        chk("lat_c2_adr", adr_o, 16'h1234);
        tx_avail = 1'b1;
        #1;
        chk("owner0_avail", ch_tx_avail, 3'b001);
        tx_avail = 1'b0;
        step();
        chk("lat_c3_stb", stb_o, 0);

        // all channels at once from a fresh pointer
        do_reset();
        adrs[0] = 16'h1000; adrs[1] = 16'h2001; adrs[2] = 16'h3002;
        for (int k = 0; k < N; k++) set_cmd(k, 1'b0, 6'(k), adrs[k], 8'(k + 1));
        step();
        ch_stb_i = '0;
`ifdef SERIALARB_PRIO_EN
        order[0] = 2; order[1] = 1; order[2] = 0;
`else
        order[0] = 0; order[1] = 1; order[2] = 2;
`endif
        for (int i = 0; i < N; i++) begin
            step();
            chk("all_stb", stb_o, 1);
            chk("all_order_adr", adr_o, adrs[order[i]]);
        end
        step();
        chk("all_done_stb", stb_o, 0);

        // make channel 1 owner, then hold channel 0 off with a response in progress
        set_cmd(1, 1'b1, 6'h11, 16'hbeef, 8'h77);
        step();
        ch_stb_i = '0;
        step();
        step();
        tx_avail = 1'b1;
        set_cmd(0, 1'b0, 6'h01, 16'haaaa, 8'h01);
        step();
        set_cmd(0, 1'b0, 6'h02, 16'hbbbb, 8'h02);
        step();
        ch_stb_i = '0;
        chk("ovf_set", ch_ovf, 3'b001);
        chk("hold_avail", ch_tx_avail, 3'b010);
        ch_tx_pull = 3'b010;
        #1;
        chk("pull_own", tx_pull, 1);
        ch_tx_pull = 3'b001;
        #1;
        chk("pull_other", tx_pull, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("holdoff_stb", stb_o, 0);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", ch_ovf, 3'b000);
        tx_avail = 1'b0;
        step();
        chk("release_stb", stb_o, 1);
        chk("release_adr", adr_o, 16'haaaa);
        step();

        // reset with slots full and a command on the output
        for (int k = 0; k < N; k++) set_cmd(k, 1'b1, 6'h3f, 16'hf00f, 8'hee);
        step();
        ch_stb_i = '0;
        @(posedge clk);
        #2;
        chk("pre_rst_stb", stb_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_stb", stb_o, 0);
        chk("rst_fields", {we_o, seq_o, adr_o, dat_o}, 0);
        chk("rst_ovf", ch_ovf, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_stb", stb_o, 0);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                ch_stb_i[k] = ($urandom_range(0, 3) == 0);
                ch_we_i[k]  = 1'($urandom);
                ch_seq_i[k*SW +: SW] = SW'($urandom);
                ch_adr_i[k*AW +: AW] = AW'($urandom);
                ch_dat_i[k*DW +: DW] = DW'($urandom);
            end
            if ($urandom_range(0, 9) == 0) tx_avail = ~tx_avail;
            ch_tx_pull = N'($urandom);
            ovf_clr    = ($urandom_range(0, 19) == 0);
            tx_data    = DW'($urandom);
            step();
        end
        ch_stb_i = '0;
        ovf_clr  = 1'b0;
        tx_avail = 1'b0;
        repeat (10) step();
        chk("queue_drained", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/serialarb.md
SERIALARB -- requirements
Module: serialarb

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of upstream command channels (legal 2..8).
REQ-002 SHALL have parameter SEQ_W, default 6, sequence field width.
REQ-003 SHALL have parameter ADR_W, default 16, address width.
REQ-004 SHALL have parameter DAT_W, default 8, data width.
REQ-005 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports ch_stb_i / ch_we_i  input  NUM_CH  per-channel command strobe / write flag.
REQ-008 SHALL have ports ch_seq_i / ch_adr_i / ch_dat_i  input  NUM_CH*SEQ_W / NUM_CH*ADR_W / NUM_CH*DAT_W  packed per-channel fields; channel k occupies slice k.
REQ-009 SHALL have port ch_tx_avail  output  NUM_CH  response available, per channel.
REQ-010 SHALL have port ch_tx_data  output  DAT_W  response byte, shared by all channels.
REQ-011 SHALL have port ch_tx_pull  input  NUM_CH  per-channel response pull.
REQ-012 SHALL have port ch_ovf  output  NUM_CH  sticky per-channel overflow flag.
REQ-013 SHALL have port ovf_clr  input  1  clears all overflow flags.
REQ-014 SHALL have ports stb_o, we_o, seq_o, adr_o, dat_o  output  1, 1, SEQ_W, ADR_W, DAT_W  downstream command.
REQ-015 SHALL have ports tx_avail / tx_data  input  1 / DAT_W  downstream response; tx_pull  output  1.

Function
REQ-016 SHALL hold one command slot per channel; ch_stb_i[k] with slot k empty (or freed the same cycle) SHALL load seq/we/adr/dat into slot k at that edge.
REQ-017 SHALL drop a command on ch_stb_i[k] arriving while slot k is full and not granted that cycle, and set ch_ovf[k] at that edge.
REQ-018 SHALL clear all ch_ovf on ovf_clr; a simultaneous overflow SHALL win (flag set).
REQ-019 SHALL grant at most one full slot per cycle; the granted slot SHALL be freed at that edge.
REQ-020 SHALL register the granted command onto stb_o/we_o/seq_o/adr_o/dat_o at the grant edge: stb_o high exactly one cycle per command; minimum latency ch_stb_i to stb_o = 2 cycles.
REQ-021 SHALL hold we_o/seq_o/adr_o/dat_o at last granted values while stb_o low.
REQ-022 SHALL keep a registered owner index; a grant to channel k SHALL set owner to k.
REQ-023 SHALL NOT grant a channel other than owner while tx_avail is high (response in progress); the owner channel SHALL remain grantable.
REQ-024 SHALL drive ch_tx_avail[owner] = tx_avail, other bits 0; tx_pull = ch_tx_pull[owner]; ch_tx_data = tx_data.
REQ-025 SHALL apply round-robin arbitration by default: after a grant to k, search order starts at (k+1) mod NUM_CH; pointer unchanged when no grant.
REQ-026 SHALL treat pointer wrap from NUM_CH-1 to 0 for non-power-of-two NUM_CH without skipping or granting nonexistent channels.

Reset
REQ-027 SHALL on rst_n low asynchronously clear all slots, ch_ovf, stb_o, we_o, seq_o, adr_o, dat_o, owner (=0) and RR pointer (=0).
REQ-028 SHALL discard slot contents when reset asserts mid-operation; no command SHALL be emitted on the first edge after release.

Configuration
REQ-029 SHALL, with SERIALARB_PRIO_EN defined, replace round-robin by fixed priority: highest-index full, eligible slot always wins; RR pointer not implemented.
REQ-030 SHALL, without SERIALARB_PRIO_EN, use round-robin per REQ-025; all other behaviour identical.

Verification
REQ-031 SHALL cover: NUM_CH=2, ch_stb_i=2'b01 adr 0x1234 at cycle 0 -> stb_o=1, adr_o=0x1234, owner=0 at cycle 2, single-cycle pulse.
REQ-032 SHALL cover: NUM_CH=3, all stb at cycle 0, tx_avail=0 -> stb_o cycles 2,3,4 grant channels 0,1,2 (RR); with SERIALARB_PRIO_EN grant order 2,1,0.
REQ-033 SHALL cover: ch0 stb at cycles 0 and 1 while ch1 slot blocks grant by priority/response hold-off -> ch_ovf=3'b001 on second strobe only if slot 0 still full; ovf_clr -> 0.
REQ-034 SHALL cover: owner=1, tx_avail=1, ch0 pending -> ch0 not granted until tx_avail=0; ch_tx_avail=2'b10, tx_pull follows ch_tx_pull[1].
REQ-035 SHALL cover: rst_n low with slots full and stb_o pending -> all outputs 0 immediately; after release no stb_o without new strobe.
